// File: rtl/vga_fb_display_if.sv
// Avalon-MM lightweight slave bus used by vga_fb_display.
interface vga_fb_display_if #(
  parameter int ADDR_W = 15
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vga_fb_display.sv
// Double-buffered framebuffer VGA controller: palette lookup, page flip at
// vertical blank, Avalon-MM slave for framebuffer and register access.
module vga_fb_display #(
  parameter int BPP        = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  localparam int PAGE_WORDS = H_ACTIVE * V_ACTIVE * BPP / 32,
  localparam int ADDR_W     = $clog2(PAGE_WORDS) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_fb_display_if.slave bus,
  output logic [7:0]      VGA_R,
  output logic [7:0]      VGA_G,
  output logic [7:0]      VGA_B,
  output logic            VGA_CLK,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_n,
  output logic            VGA_SYNC_n
);

  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOT);
  localparam int VW        = $clog2(V_TOT);
  localparam int RAM_WORDS = 2 * PAGE_WORDS;
  localparam int RAW       = $clog2(RAM_WORDS);
  localparam int PPW       = 32 / BPP;
  localparam int SH        = $clog2(PPW);
  localparam int PAL_N     = 2 ** BPP;
  localparam int OFF_W     = ADDR_W - 1;

  logic            phase;
  logic            pix_en;
  logic [HW-1:0]   hcount;
  logic [VW-1:0]   vcount;
  logic            active, hs_n, vs_n, vblank, swap;

  logic            front_page, flip_pending;
  logic [15:0]     frame_cnt;

  logic            is_reg;
  logic [31:0]     off32;
  logic            fb_wr, flip_wr, pal_wr, bus_rd;
  logic [BPP-1:0]  pal_sel;
  logic [RAW-1:0]  wr_idx, rd_idx;

  logic [31:0]     mem [RAM_WORDS];
  logic [31:0]     rd_word;
  logic [23:0]     palette [PAL_N];

  logic            s1_active, s1_hs_n, s1_vs_n;
  logic [SH-1:0]   s1_k;
  logic [BPP-1:0]  pix_idx;

  assign pix_en     = phase;
  assign VGA_CLK    = phase;
  assign VGA_SYNC_n = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      phase <= ~phase;
      if (pix_en) begin
        if (hcount == HW'(H_TOT - 1)) begin
          hcount <= '0;
          vcount <= (vcount == VW'(V_TOT - 1)) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  always_comb begin
    active = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
    hs_n   = !((hcount >= HW'(H_ACTIVE + H_FP)) && (hcount < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_n   = !((vcount >= VW'(V_ACTIVE + V_FP)) && (vcount < VW'(V_ACTIVE + V_FP + V_SYNC)));
    vblank = (vcount >= VW'(V_ACTIVE));
    swap   = pix_en && (hcount == '0) && (vcount == VW'(V_ACTIVE));
  end

  // Scan word address for the current pixel; out of the active region the
  // read is parked at word 0 since its data is never shown.
  always_comb begin
    rd_idx = '0;
    if (active)
      rd_idx = RAW'(((32'(vcount) * 32'(H_ACTIVE) + 32'(hcount)) >> SH)
                    + (front_page ? 32'(PAGE_WORDS) : 32'd0));
  end

  always_comb begin
    is_reg  = bus.address[ADDR_W-1];
    off32   = 32'(bus.address[OFF_W-1:0]);
    bus_rd  = bus.chipselect && bus.read;
    fb_wr   = bus.chipselect && bus.write && !is_reg && (off32 < 32'(PAGE_WORDS));
    flip_wr = bus.chipselect && bus.write && is_reg && (off32 == 32'd0);
    pal_wr  = bus.chipselect && bus.write && is_reg &&
              (off32 >= 32'd256) && (off32 < 32'(256 + PAL_N));
    pal_sel = BPP'(off32 - 32'd256);
    wr_idx  = RAW'(off32 + (front_page ? 32'd0 : 32'(PAGE_WORDS)));
  end

  always_ff @(posedge clk) begin
    if (fb_wr)
      mem[wr_idx] <= bus.writedata;
    if (pix_en)
      rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PAL_N; i++)
        palette[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
    end else if (pal_wr) begin
      palette[pal_sel] <= bus.writedata[23:0];
    end
  end

  // A FLIP write always wins over the clear at the swap point, so a request
  // landing in the swap clk is held for the following vblank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_page   <= 1'b0;
      flip_pending <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (swap) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (flip_pending)
          front_page <= ~front_page;
      end
      if (flip_wr)
        flip_pending <= 1'b1;
      else if (swap)
        flip_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.readdata <= '0;
    else if (bus_rd && is_reg && (off32 == 32'd1))
      bus.readdata <= {frame_cnt, 13'b0, vblank, flip_pending, front_page};
    else
      bus.readdata <= '0;
  end

  always_comb begin
    pix_idx = BPP'(rd_word >> (32'(s1_k) * 32'(BPP)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_active   <= 1'b0;
      s1_hs_n     <= 1'b1;
      s1_vs_n     <= 1'b1;
      s1_k        <= '0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else if (pix_en) begin
      s1_active   <= active;
      s1_hs_n     <= hs_n;
      s1_vs_n     <= vs_n;
      s1_k        <= SH'(hcount);
      {VGA_R, VGA_G, VGA_B} <= s1_active ? palette[pix_idx] : 24'h000000;
      VGA_HS      <= s1_hs_n;
      VGA_VS      <= s1_vs_n;
      VGA_BLANK_n <= s1_active;
    end
  end

endmodule

// File: tb/tb_vga_fb_display.sv
// Directed bench for vga_fb_display on a reduced 64x40, 4-bpp raster so that
// several whole frames fit in a short run.
module tb_vga_fb_display;

  localparam int BPP = 4;
  localparam int HA = 64, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 40, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;          // 72 pixels
  localparam int VT = VA + VFP + VSY + VBP;          // 44 lines
  localparam int PW = HA * VA * BPP / 32;            // 320 words
  localparam int AW = $clog2(PW) + 1;                // 10
  localparam int FR = 2 * HT * VT;                   // clk per frame
  localparam int SW0 = 2 * (VA * HT + 1);            // first swap edge
  localparam int R_FLIP = 1 << (AW - 1);
  localparam int R_STAT = R_FLIP + 1;
  localparam int R_PAL  = R_FLIP + 256;

  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] r, g, b;
  logic vclk, hs, vs, blank_n, sync_n;
  int   cyc;
  int   total = 0;
  int   bad = 0;

  vga_fb_display_if #(.ADDR_W(AW)) bus ();

  vga_fb_display #(
    .BPP(BPP), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vclk),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_n(blank_n), .VGA_SYNC_n(sync_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    int          off;
    logic        blank;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int fc, input bit vb, input bit pend, input bit front);
    return {16'(fc), 13'b0, vb, pend, front};
  endfunction

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1;
    bus.address = AW'(a); bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = AW'(a);
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wait_blank_rise(output int t);
    t = -1;
    for (int i = 0; i < 1000; i++) begin
      if (blank_n) begin t = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_fall(input bit use_vs, input int budget, output int t);
    logic prev, cur;
    t = -1;
    prev = use_vs ? vs : hs;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cur = use_vs ? vs : hs;
      if (prev && !cur) begin t = cyc; break; end
      prev = cur;
    end
  endtask

  task automatic run_table(input int base, input string tag);
    for (int i = 0; i < 13; i++) begin
      at_cyc(base + tbl[i].off);
      chk($sformatf("%s_blank@%0d", tag, tbl[i].off), 32'(blank_n), 32'(tbl[i].blank));
      chk($sformatf("%s_rgb@%0d", tag, tbl[i].off), {8'h0, r, g, b}, {8'h0, tbl[i].rgb});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int t1, t2, act_cnt, wrong;
    logic pv, cv;

    // line-0 pixels after the palette test: x=0..3 -> idx 0..3, x=4 -> idx 0, x>=8 -> idx 15
    tbl[0]  = '{3,   1'b0, 24'h000000};
    tbl[1]  = '{4,   1'b1, 24'h000000};
    tbl[2]  = '{5,   1'b1, 24'h000000};
    tbl[3]  = '{6,   1'b1, 24'hFF0000};
    tbl[4]  = '{7,   1'b1, 24'hFF0000};
    tbl[5]  = '{8,   1'b1, 24'h00FF00};
    tbl[6]  = '{9,   1'b1, 24'h00FF00};
    tbl[7]  = '{10,  1'b1, 24'h0000FF};
    tbl[8]  = '{11,  1'b1, 24'h0000FF};
    tbl[9]  = '{12,  1'b1, 24'h000000};
    tbl[10] = '{20,  1'b1, 24'hFFFFFF};
    tbl[11] = '{131, 1'b1, 24'hFFFFFF};
    tbl[12] = '{132, 1'b0, 24'h000000};

    reset_n = 1'b0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    repeat (5) @(negedge clk);
    chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_blank", 32'(blank_n), 32'd0);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("sync_n", 32'(sync_n), 32'd0);
    reset_n = 1'b1;

    wait_blank_rise(t1);
    chk("first_blank_rise", t1, 32'd4);
    wait_fall(1'b0, 400, t1);
    chk("first_hs_fall", t1, 32'(2 * (HA + HFP) + 4));
    wait_fall(1'b0, 400, t2);
    chk("hs_period", t2 - t1, 32'(2 * HT));

    at_cyc(400);
    for (int i = 0; i < PW; i++) bus_write(i, 32'hFFFF_FFFF);
    bus_write(R_FLIP, 32'h1);
    at_cyc(1100);
    bus_read(R_STAT, rd);
    chk("stat_pending", rd, st(0, 0, 1, 0));

    at_cyc(5800);
    bus_read(R_STAT, rd);
    chk("stat_after_flip", rd, st(1, 1, 0, 1));

    wait_fall(1'b1, 7000, t1);
    chk("first_vs_fall", t1, 32'(2 * (VA + VFP) * HT + 4));
    t2 = -1; act_cnt = 0; wrong = 0; pv = vs;
    for (int i = 0; i < FR + 2; i++) begin
      @(negedge clk);
      cv = vs;
      if (pv && !cv && t2 < 0) t2 = cyc;
      pv = cv;
      if (blank_n) begin
        act_cnt++;
        if ({r, g, b} !== 24'hFFFFFF) wrong++;
      end
    end
    chk("vs_period", t2 - t1, 32'(FR));
    chk("white_active_samples", act_cnt, 32'(2 * HA * VA));
    chk("white_wrong_pixels", wrong, 32'd0);

    at_cyc(12300);
    bus_write(R_FLIP, 32'h1);
    bus_write(R_FLIP, 32'h1);
    at_cyc(12400);
    bus_read(R_STAT, rd);
    chk("stat_double_flip", rd, st(2, 1, 1, 1));
    at_cyc(18500);
    bus_read(R_STAT, rd);
    chk("stat_one_swap", rd, st(3, 1, 0, 0));
    at_cyc(24900);
    bus_read(R_STAT, rd);
    chk("stat_no_extra_swap", rd, st(4, 1, 0, 0));

    at_cyc(25000);
    bus_write(R_FLIP, 32'h1);
    at_cyc(SW0 + 4 * FR - 1);
    bus_write(R_FLIP, 32'h1);
    at_cyc(31200);
    bus_read(R_STAT, rd);
    chk("stat_collision", rd, st(5, 1, 1, 1));
    at_cyc(37540);
    bus_read(R_STAT, rd);
    chk("stat_second_swap", rd, st(6, 1, 0, 0));

    at_cyc(37600);
    bus_write(R_PAL + 0, 32'h0000_0000);
    bus_write(R_PAL + 1, 32'h00FF_0000);
    bus_write(R_PAL + 2, 32'h0000_FF00);
    bus_write(R_PAL + 3, 32'h0000_00FF);
    bus_write(0, 32'h0000_3210);
    bus_write(R_FLIP, 32'h1);
    run_table(7 * FR, "pal_f7");

    at_cyc(44500);
    bus_write(PW, 32'hFFFF_FFFF);
    at_cyc(44600);
    bus_read(R_STAT, rd);
    chk("stat_after_oob", rd, st(7, 0, 0, 1));
    run_table(8 * FR, "oob_f8");

    at_cyc(9 * FR + 20 * 2 * HT + 60);
    chk("pre_reset_blank", 32'(blank_n), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rgb", {8'h0, r, g, b}, 32'h0);
    chk("mid_rst_hs", 32'(hs), 32'd1);
    chk("mid_rst_vs", 32'(vs), 32'd1);
    chk("mid_rst_blank", 32'(blank_n), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(R_STAT, rd);
    chk("stat_after_reset", rd, st(0, 0, 0, 0));
    wait_blank_rise(t1);
    chk("restart_blank_rise", t1, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_display.md
Name: vga_fb_display

Overview:
Parametrised double-buffered framebuffer VGA controller. It is the successor to the 1-bpp vga_ball display: configurable bits per pixel through a palette, two pages with a page flip at vertical blank, and a readable status register. It sits on the Avalon-MM lightweight bus as a slave and drives the VGA DAC pins directly.

Parameters:
BPP, 1, bits per pixel. Legal values are 1, 2, 4 and 8. Palette depth is 2**BPP.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
Derived: PAGE_WORDS = H_ACTIVE*V_ACTIVE*BPP/32.
Derived: ADDR_W = clog2(PAGE_WORDS)+1.

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
chipselect  in  1  Avalon slave select
write  in  1  write strobe, qualified by chipselect
read  in  1  read strobe, qualified by chipselect
address  in  ADDR_W  word address; MSB=0 selects framebuffer, MSB=1 selects registers
writedata  in  32  write data
readdata  out  32  read data, read latency 1
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
VGA_CLK  out  1  pixel clock = clk/2
VGA_HS, VGA_VS  out  1  sync outputs, active low
VGA_BLANK_n  out  1  high during the active region
VGA_SYNC_n  out  1  tied to 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - RGB = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_n = 0, readdata = 0.
  - hcount = vcount = 0, front_page = 0, flip_pending = 0, frame_cnt = 0.
  - Palette entry 0 = 0x000000; all other entries = 0xFFFFFF, so BPP=1 behaves exactly like the 1-bpp vga_ball.
  - Framebuffer RAM contents are not reset.
- Timing:
  - Pixel enable asserts on every second clk; VGA_CLK is the phase bit.
  - hcount runs 0..H_total-1 and increments once per pixel. vcount increments when hcount wraps.
  - HS is low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS is defined the same way on vcount.
  - Active region is hcount < H_ACTIVE and vcount < V_ACTIVE.
- Framebuffer:
  - RAM holds 2*PAGE_WORDS x 32 and is dual-ported: one bus write port, one scan read port with 1 clk latency.
  - A bus write with address MSB=0 and offset < PAGE_WORDS stores to the back page: word (~front_page)*PAGE_WORDS + offset.
  - Offsets >= PAGE_WORDS are ignored.
- Pixel packing:
  - Pixel (x,y) lives at word (y*H_ACTIVE+x)*BPP/32.
  - Within the word it occupies bits [BPP*k +: BPP], with k = x mod (32/BPP), LSB pixel first.
- Scan pipeline:
  - The word is prefetched so that RGB = palette[index] appears exactly 2 pixel periods after its hcount/vcount.
  - HS, VS and BLANK_n are delayed by the same 2 pixel periods, so all outputs stay aligned.
  - RGB is forced to 0 outside the active region.
- Registers (address MSB=1, low bits = reg index):
  - 0 FLIP, write-only: any write sets flip_pending. A write while flip_pending is already 1 has no effect.
  - 1 STATUS, read-only: bit0 front_page, bit1 flip_pending, bit2 vblank (vcount >= V_ACTIVE), [31:16] frame_cnt.
  - 256+i PALETTE[i], write-only: writedata[23:0] = {R,G,B}, for i < 2**BPP. Writes to other indices are ignored.
  - The palette is read by the scan path; a write takes effect from the next clk.
- Reads: readdata is registered one clk after chipselect&&read. Reads of framebuffer space or undefined registers return 0.
- Page flip:
  - The swap point is the clk where the pixel enable is asserted, hcount==0 and vcount==V_ACTIVE.
  - If flip_pending=1 at the swap point: front_page toggles and flip_pending clears.
  - frame_cnt increments at every swap point, whether or not a flip occurred, and wraps at 16 bits.
- Simultaneous events:
  - A FLIP write in the same clk as a swap: the swap occurs and flip_pending ends the cycle at 1, so the next swap happens at the following vblank.
  - A framebuffer write in the swap clk uses the pre-swap back page.
- Reset mid-frame: all counters and outputs return to their reset values asynchronously. Scanning restarts at (0,0) with front_page = 0 after reset_n rises.

Test Plan:
- Reset: hold reset_n=0 for 5 clk -> RGB=0, HS=1, VS=1, BLANK_n=0; the HS period is 1600 clk and the VS period is 840000 clk.
- BPP=1 page flip: fill page offsets 0..9599 with 0xFFFFFFFF, then write FLIP. The visible frame stays black until vblank; on the next frame every active pixel is 0xFFFFFF. STATUS then reads bit0=1, bit1=0.
- Flip idempotence and collision: write FLIP twice before vblank -> exactly one swap. Write FLIP in the swap clk -> swap occurs, STATUS bit1=1, and a second swap happens at the next vblank.
- BPP=2 palette: set PALETTE[0..3] = 0x000000, 0xFF0000, 0x00FF00, 0x0000FF; write word 0 = 0x000000E4 and flip -> pixels x=0..3 of line 0 show black, red, green, blue, aligned with BLANK_n rising.
- Out-of-range write: write to offset PAGE_WORDS with 0xFFFFFFFF -> no framebuffer change, and a STATUS read returns the same value as before the write.
- Reset mid-frame: drop reset_n at vcount=200 -> outputs return to reset values immediately; after release, front_page=0 and frame_cnt=0.
